// File: rtl/prog_memory_if.sv
// Program memory bus: fetch port (pc/stall -> inst/inst_valid/fault) and
// program-load stream (ld_start/ld_valid/ld_data/ld_last -> ld_ready/ld_count).
//   master : fetch/load requester (core or loader)
//   slave  : prog_memory
// DEPTH must match the prog_memory instance so that ld_count widths agree.
interface prog_memory_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 128
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [31:0]       pc;
   logic              stall;
   logic [DATA_W-1:0] inst;
   logic              inst_valid;
   logic              fault;
   logic              ld_start;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              ld_ready;
   logic [AW:0]       ld_count;
   logic              running;

   modport master (
      output pc, stall, ld_start, ld_valid, ld_data, ld_last,
      input  inst, inst_valid, fault, ld_ready, ld_count, running
   );

   modport slave (
      input  pc, stall, ld_start, ld_valid, ld_data, ld_last,
      output inst, inst_valid, fault, ld_ready, ld_count, running
   );
endinterface

// File: rtl/prog_memory.sv
// Loadable instruction memory with a registered fetch port.
// A load stream fills words from index 0 (IDLE/LOAD -> RUN on ld_last or a
// full memory); in RUN each unstalled cycle registers the word at pc.
// Out-of-range or misaligned fetches return NOP_WORD and set a sticky fault.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : prog_memory_if.slave (fetch and load signals)
module prog_memory #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       DEPTH     = 128,
   parameter int unsigned       BYTE_ADDR = 1,
   parameter logic [DATA_W-1:0] NOP_WORD  = {DATA_W{1'b0}}
) (
   input logic          clk,
   input logic          rst_n,
   prog_memory_if.slave bus
);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);
   localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   state_e            state_q;
   logic [AW:0]       ld_count_q;
   logic [DATA_W-1:0] inst_q;
   logic              inst_valid_q;
   logic              fault_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [AW-1:0]     fetch_idx;
   logic              fetch_bad;
   logic              ld_accept;
   logic              ld_end;

   // Address decode: byte addresses must be word aligned and within range.
   always_comb begin
      if (BYTE_ADDR != 0) begin
         fetch_idx = bus.pc[AW+1:2];
         fetch_bad = ((bus.pc >> (AW + 2)) != 32'd0) || (bus.pc[1:0] != 2'b00);
      end else begin
         fetch_idx = bus.pc[AW-1:0];
         fetch_bad = (bus.pc >> AW) != 32'd0;
      end
   end

   // ld_start wins over a coincident data beat, so that beat is dropped.
   assign ld_accept = (state_q == StLoad) && bus.ld_valid && !bus.ld_start;
   assign ld_end    = bus.ld_last || (ld_count_q == LAST_IDX);

   // Storage has no reset; contents survive reset and aborted loads.
   always_ff @(posedge clk) begin
      if (ld_accept) begin
         mem[ld_count_q[AW-1:0]] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ld_count_q   <= '0;
         inst_q       <= NOP_WORD;
         inst_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else if (bus.ld_start) begin
         state_q      <= StLoad;
         ld_count_q   <= '0;
         inst_q       <= NOP_WORD;
         inst_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               inst_q       <= NOP_WORD;
               inst_valid_q <= 1'b0;
            end
            StLoad: begin
               inst_q       <= NOP_WORD;
               inst_valid_q <= 1'b0;
               if (ld_accept) begin
                  ld_count_q <= ld_count_q + CNT_ONE;
                  if (ld_end) begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               if (!bus.stall) begin
                  if (fetch_bad) begin
                     inst_q       <= NOP_WORD;
                     inst_valid_q <= 1'b0;
                     fault_q      <= 1'b1;
                  end else begin
                     inst_q       <= mem[fetch_idx];
                     inst_valid_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q      <= StIdle;
               inst_q       <= NOP_WORD;
               inst_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.inst       = inst_q;
   assign bus.inst_valid = inst_valid_q;
   assign bus.fault      = fault_q;
   assign bus.ld_ready   = (state_q == StLoad);
   assign bus.ld_count   = ld_count_q;
   assign bus.running    = (state_q == StRun);
endmodule
